// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store and memory-side signals of mem_port_arbiter.
// The d_err signal exists only when MEM_ALIGN_CHECK_EN is defined.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;

  // load/store requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
`ifdef MEM_ALIGN_CHECK_EN
  logic              d_err;
`endif

  // shared memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_done,
`ifdef MEM_ALIGN_CHECK_EN
    output d_err,
`endif
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // Requesters and memory side
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_done,
`ifdef MEM_ALIGN_CHECK_EN
    input  d_err,
`endif
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store with
// a fetch-fairness bit. Optional misaligned-data trap: define MEM_ALIGN_CHECK_EN.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_IF = 2'd1,
    ACC_D  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt;
  logic              fair_if;
  logic              is_data;
  logic              we_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic              grant_if;
  logic              grant_data;
  logic              misalign;
  logic              in_access;
  logic              last_beat;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (bus.d_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign in_access = (state == ACC_IF) || (state == ACC_D);
  assign last_beat = in_access && (cnt == '0);

  // Arbitration and next state. Data wins a tie unless fetch is owed a turn.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d    = state;
    grant_if   = 1'b0;
    grant_data = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.d_req && (!bus.if_req || !fair_if)) begin
          grant_data = 1'b1;
          state_d    = misalign ? DONE : ACC_D;
        end else if (bus.if_req) begin
          grant_if = 1'b1;
          state_d  = ACC_IF;
        end
      end
      ACC_IF, ACC_D: begin
        if (cnt == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: asynchronous active-high reset; sequential state uses non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Grant latching, latency counter, fairness bit and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      fair_if    <= 1'b0;
      is_data    <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (grant_data) begin
        addr_q  <= bus.d_addr;
        we_q    <= bus.d_we;
        wdata_q <= bus.d_wdata;
        is_data <= 1'b1;
        err_q   <= misalign;
        cnt     <= CNT_LOAD;
        // A data grant with fetch also waiting owes fetch the next tie.
        if (bus.if_req) fair_if <= 1'b1;
      end else if (grant_if) begin
        addr_q  <= bus.if_addr;
        we_q    <= 1'b0;
        wdata_q <= '0;
        is_data <= 1'b0;
        err_q   <= 1'b0;
        cnt     <= CNT_LOAD;
        fair_if <= 1'b0;
      end

      if (in_access && (cnt != '0)) cnt <= cnt - 1'b1;

      if (last_beat) begin
        if (state == ACC_IF)  if_rdata_q <= bus.mem_rdata;
        else if (!we_q)       d_rdata_q  <= bus.mem_rdata;
      end
    end
  end

  // Strobes decode from state so a reset mid-access drops them at once.
  assign bus.mem_en    = in_access;
  assign bus.mem_we    = (state == ACC_D) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_valid  = (state == DONE) && !is_data;
  assign bus.d_done    = (state == DONE) && is_data;
  assign bus.busy      = (state != IDLE);
`ifdef MEM_ALIGN_CHECK_EN
  assign bus.d_err     = (state == DONE) && err_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then random
// traffic, checked against a transaction-level model of grant order and timing.
module tb_mem_port_arbiter;

  localparam int LAT = 3;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference model: pending requests, tie-break owed to fetch, held read data.
  logic        if_pend, d_pend, m_fair;
  logic [31:0] if_a, d_a, d_wd;
  logic        d_w;
  logic [31:0] exp_if, exp_d;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic req_if(input logic [31:0] a);
    if_pend = 1'b1; if_a = a;
    bus.if_req = 1'b1; bus.if_addr = a;
  endtask

  task automatic req_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
    d_pend = 1'b1; d_w = we; d_a = a; d_wd = wd;
    bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
  endtask

  task automatic chk_idle();
    chk1("idle_busy", bus.busy, 1'b0);
    chk1("idle_mem_en", bus.mem_en, 1'b0);
    chk1("idle_if_valid", bus.if_valid, 1'b0);
    chk1("idle_d_done", bus.d_done, 1'b0);
  endtask

  // Called at the falling edge of an IDLE cycle with requests already driven;
  // returns at the falling edge of the next IDLE cycle.
  task automatic round(input logic [31:0] rd);
    logic        win_d, ewe, err;
    logic [31:0] ea, ewd;
    chk_idle();
    @(posedge clk);
    if (!if_pend && !d_pend) begin
      @(negedge clk);
      return;
    end
    if (d_pend && (!if_pend || !m_fair)) begin
      win_d = 1'b1;
      if (if_pend) m_fair = 1'b1;
    end else begin
      win_d  = 1'b0;
      m_fair = 1'b0;
    end
    ea  = win_d ? d_a  : if_a;
    ewe = win_d ? d_w  : 1'b0;
    ewd = win_d ? d_wd : 32'h0;
    err = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    err = win_d && (ea[1:0] != 2'b00);
`endif
    if (!err) begin
      for (int i = 0; i < LAT; i++) begin
        @(negedge clk);
        chk1("acc_mem_en", bus.mem_en, 1'b1);
        chk1("acc_mem_we", bus.mem_we, ewe);
        chk32("acc_mem_addr", bus.mem_addr, ea);
        if (win_d) chk32("acc_mem_wdata", bus.mem_wdata, ewd);
        chk1("acc_busy", bus.busy, 1'b1);
        chk1("acc_if_valid", bus.if_valid, 1'b0);
        chk1("acc_d_done", bus.d_done, 1'b0);
        if (i == 0) begin
          // Requester inputs after the grant edge must not matter.
          if (win_d) begin
            bus.d_addr = $urandom; bus.d_wdata = $urandom; bus.d_we = 1'($urandom);
          end else begin
            bus.if_addr = $urandom;
          end
        end
        bus.mem_rdata = (i == LAT - 1) ? rd : $urandom;
      end
      if (win_d && !ewe) exp_d  = rd;
      if (!win_d)        exp_if = rd;
    end
    @(negedge clk);
    chk1("done_mem_en", bus.mem_en, 1'b0);
    chk1("done_mem_we", bus.mem_we, 1'b0);
    chk1("done_busy", bus.busy, 1'b1);
    chk1("done_if_valid", bus.if_valid, !win_d);
    chk1("done_d_done", bus.d_done, win_d);
    chk32("done_if_rdata", bus.if_rdata, exp_if);
    chk32("done_d_rdata", bus.d_rdata, exp_d);
`ifdef MEM_ALIGN_CHECK_EN
    chk1("done_d_err", bus.d_err, err);
`endif
    if (win_d) begin d_pend = 1'b0; bus.d_req = 1'b0; end
    else       begin if_pend = 1'b0; bus.if_req = 1'b0; end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ra;
    n_tests = 0; n_fail = 0;
    if_pend = 0; d_pend = 0; m_fair = 0;
    if_a = 0; d_a = 0; d_wd = 0; d_w = 0;
    exp_if = 0; exp_d = 0;
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk1("rst_mem_en", bus.mem_en, 1'b0);
    chk1("rst_mem_we", bus.mem_we, 1'b0);
    chk32("rst_mem_addr", bus.mem_addr, 32'h0);
    chk32("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk32("rst_if_rdata", bus.if_rdata, 32'h0);
    chk32("rst_d_rdata", bus.d_rdata, 32'h0);
    chk1("rst_busy", bus.busy, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
    chk1("rst_d_err", bus.d_err, 1'b0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Lone fetch, store, load, then a fetch that must leave d_rdata alone.
    req_if(32'h100);                      round(32'hE281_1001);
    req_d(1'b1, 32'h40, 32'hDEAD_BEEF);   round($urandom);
    req_d(1'b0, 32'h80, 32'h0);           round(32'h1234_5678);
    req_if(32'h104);                      round($urandom);

    // Contested requests with data re-asserted after each completion.
    req_if(32'h500); req_d(1'b1, 32'h600, $urandom); round($urandom);
    req_d(1'b0, 32'h604, 32'h0);                     round($urandom);
    req_if(32'h504);                                 round($urandom);
    req_d(1'b1, 32'h608, $urandom);                  round($urandom);
    round($urandom);

    // Leave fetch owed a turn, then reset in the middle of a data access.
    req_if(32'h200); req_d(1'b0, 32'h300, 32'h0); round($urandom);
    bus.if_req = 1'b0; if_pend = 1'b0;
    req_d(1'b0, 32'h44, 32'h0);
    chk_idle();
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk1("pre_rst_mem_en", bus.mem_en, 1'b1);
    rst = 1'b1;
    #1;
    chk1("midrst_mem_en", bus.mem_en, 1'b0);
    chk1("midrst_mem_we", bus.mem_we, 1'b0);
    chk1("midrst_busy", bus.busy, 1'b0);
    chk1("midrst_d_done", bus.d_done, 1'b0);
    bus.d_req = 1'b0; d_pend = 1'b0;
    m_fair = 1'b0; exp_if = 32'h0; exp_d = 32'h0;
    @(posedge clk);
    @(negedge clk);
    chk1("midrst_no_done", bus.d_done, 1'b0);
    chk32("midrst_d_rdata", bus.d_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    req_if(32'h108); req_d(1'b0, 32'h88, 32'h0); round($urandom);
    round($urandom);

`ifdef MEM_ALIGN_CHECK_EN
    req_d(1'b0, 32'h42, 32'h0); round($urandom);
    req_if(32'h10C);            round($urandom);
`endif

    for (int n = 0; n < 40; n++) begin
      if (!if_pend && ($urandom_range(0, 2) != 0)) req_if($urandom);
      if (!d_pend && ($urandom_range(0, 2) != 0)) begin
        ra = $urandom;
        if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
        req_d(1'($urandom), ra, $urandom);
      end
      round($urandom);
    end
    round($urandom);
    round($urandom);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
